// File: rtl/m68k_bus_ctrl_if.sv
// Signal bundle between the 68000 pins, m68k_bus_ctrl and its on-board slaves.
// master = the bus controller's view, slave = the CPU pins plus the slave responder.
interface m68k_bus_ctrl_if #(
  parameter int ADDR_W = 23
);
  logic              as_n;
  logic              uds_n;
  logic              lds_n;
  logic              r_w_n;
  logic [ADDR_W-1:0] addr_in;
  logic [15:0]       data_in;
  logic              dtack_n;
  logic              berr_n;
  logic              dir;
  logic [15:0]       data_out;
  logic              req;
  logic [ADDR_W-1:0] req_addr;
  logic              req_we;
  logic [1:0]        req_be;
  logic [15:0]       req_wdata;
  logic              ack;
  logic [15:0]       rdata;

  modport master (
    input  as_n, uds_n, lds_n, r_w_n, addr_in, data_in, ack, rdata,
    output dtack_n, berr_n, dir, data_out, req, req_addr, req_we, req_be, req_wdata
  );

  modport slave (
    output as_n, uds_n, lds_n, r_w_n, addr_in, data_in, ack, rdata,
    input  dtack_n, berr_n, dir, data_out, req, req_addr, req_we, req_be, req_wdata
  );
endinterface

// File: rtl/m68k_bus_ctrl.sv
// 68000 asynchronous bus front end: strobe synchronisers, cycle FSM, req/ack slave port.
// Optional bus-error timeout enabled by defining M68K_BUS_TIMEOUT_EN.
module m68k_bus_ctrl #(
  parameter int ADDR_W         = 23,
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic            clk12,
  input  logic            rst,
  m68k_bus_ctrl_if.master bus
);
  typedef enum logic [2:0] {S_IDLE, S_WAIT_DS, S_REQ, S_DTACK, S_ERR} state_t;

  state_t            r_state, w_state_next;
  logic [3:0]        r_sync [SYNC_STAGES];
  logic              w_as, w_uds, w_lds, w_rw;
  logic              r_armed, w_armed_next;
  logic              r_req, w_req_next;
  logic              r_dtack_n, w_dtack_n_next;
  logic              r_dir, w_dir_next;
  logic [15:0]       r_data_out, w_data_out_next;
  logic [ADDR_W-1:0] r_req_addr, w_req_addr_next;
  logic              r_req_we, w_req_we_next;
  logic [1:0]        r_req_be, w_req_be_next;
  logic [15:0]       r_req_wdata, w_req_wdata_next;

`ifdef M68K_BUS_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0]  r_tmo, w_tmo_next;
  logic              r_berr_n, w_berr_n_next;
  logic              w_tmo_hit;
  assign w_tmo_hit = (r_tmo == TMO_W'(TIMEOUT_CYCLES - 1));
`endif

  // AS resets to "asserted" so a strobe already low at reset release can never arm a cycle.
  always_ff @(posedge clk12) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) r_sync[i] <= 4'b0111;
    end else begin
      r_sync[0] <= {bus.as_n, bus.uds_n, bus.lds_n, bus.r_w_n};
      for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
    end
  end

  assign {w_as, w_uds, w_lds, w_rw} = r_sync[SYNC_STAGES-1];

  always_comb begin
    w_state_next     = r_state;
    w_armed_next     = r_armed | w_as;
    w_req_next       = r_req;
    w_dtack_n_next   = r_dtack_n;
    w_dir_next       = r_dir;
    w_data_out_next  = r_data_out;
    w_req_addr_next  = r_req_addr;
    w_req_we_next    = r_req_we;
    w_req_be_next    = r_req_be;
    w_req_wdata_next = r_req_wdata;
`ifdef M68K_BUS_TIMEOUT_EN
    w_tmo_next       = r_tmo;
    w_berr_n_next    = r_berr_n;
`endif
    case (r_state)
      S_IDLE: begin
        if (!w_as && r_armed) begin
          w_state_next = S_WAIT_DS;
          w_armed_next = 1'b0;
        end
      end
      S_WAIT_DS: begin
        if (w_as) begin
          w_state_next = S_IDLE;
        end else if (!w_uds || !w_lds) begin
          w_req_addr_next  = bus.addr_in;
          w_req_we_next    = ~w_rw;
          w_req_be_next    = {~w_uds, ~w_lds};
          w_req_wdata_next = bus.data_in;
          w_req_next       = 1'b1;
`ifdef M68K_BUS_TIMEOUT_EN
          w_tmo_next       = '0;
`endif
          w_state_next     = S_REQ;
        end
      end
      S_REQ: begin
        // A CPU that has already ended the cycle must not see a late DTACK.
        if (w_as) begin
          w_req_next   = 1'b0;
          w_state_next = S_IDLE;
        end else if (bus.ack) begin
          w_data_out_next = bus.rdata;
          w_req_next      = 1'b0;
          w_dtack_n_next  = 1'b0;
          w_dir_next      = ~r_req_we;
          w_state_next    = S_DTACK;
        end
`ifdef M68K_BUS_TIMEOUT_EN
        else if (w_tmo_hit) begin
          w_req_next    = 1'b0;
          w_berr_n_next = 1'b0;
          w_state_next  = S_ERR;
        end else begin
          w_tmo_next = r_tmo + 1'b1;
        end
`endif
      end
      S_DTACK: begin
        if (w_as) begin
          w_dtack_n_next = 1'b1;
          w_dir_next     = 1'b0;
          w_state_next   = S_IDLE;
        end
      end
`ifdef M68K_BUS_TIMEOUT_EN
      S_ERR: begin
        if (w_as) begin
          w_berr_n_next = 1'b1;
          w_state_next  = S_IDLE;
        end
      end
`endif
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk12) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_armed     <= 1'b0;
      r_req       <= 1'b0;
      r_dtack_n   <= 1'b1;
      r_dir       <= 1'b0;
      r_data_out  <= '0;
      r_req_addr  <= '0;
      r_req_we    <= 1'b0;
      r_req_be    <= '0;
      r_req_wdata <= '0;
`ifdef M68K_BUS_TIMEOUT_EN
      r_tmo       <= '0;
      r_berr_n    <= 1'b1;
`endif
    end else begin
      r_state     <= w_state_next;
      r_armed     <= w_armed_next;
      r_req       <= w_req_next;
      r_dtack_n   <= w_dtack_n_next;
      r_dir       <= w_dir_next;
      r_data_out  <= w_data_out_next;
      r_req_addr  <= w_req_addr_next;
      r_req_we    <= w_req_we_next;
      r_req_be    <= w_req_be_next;
      r_req_wdata <= w_req_wdata_next;
`ifdef M68K_BUS_TIMEOUT_EN
      r_tmo       <= w_tmo_next;
      r_berr_n    <= w_berr_n_next;
`endif
    end
  end

  assign bus.dtack_n   = r_dtack_n;
  assign bus.dir       = r_dir;
  assign bus.data_out  = r_data_out;
  assign bus.req       = r_req;
  assign bus.req_addr  = r_req_addr;
  assign bus.req_we    = r_req_we;
  assign bus.req_be    = r_req_be;
  assign bus.req_wdata = r_req_wdata;
`ifdef M68K_BUS_TIMEOUT_EN
  assign bus.berr_n    = r_berr_n;
`else
  assign bus.berr_n    = 1'b1;
`endif
endmodule

// File: tb/tb_m68k_bus_ctrl.sv
// Bench for m68k_bus_ctrl: table-driven and random bus cycles checked cycle by cycle
// against timing derived from the pin-to-output latencies, plus reset/timeout sequences.
module tb_m68k_bus_ctrl;
  localparam int ADDR_W = 23;
  localparam int S      = 2;
  localparam int TO     = 64;

  logic clk12 = 1'b0;
  logic rst   = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk12 = ~clk12;

  m68k_bus_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

  m68k_bus_ctrl #(
    .ADDR_W(ADDR_W), .SYNC_STAGES(S), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk12(clk12),
    .rst  (rst),
    .bus  (bus.master)
  );

  typedef struct {
    logic              rd;
    logic [1:0]        be;
    logic [ADDR_W-1:0] addr;
    logic [15:0]       wdata;
    logic [15:0]       rdata;
    int                dly;    // cycles between req rise and ack (or AS rise when aborting)
    logic              tied;   // ack held high throughout
    logic              abort;
    int                hold;   // cycles AS stays low after DTACK
    logic [ADDR_W-1:0] e_addr;
    logic              e_we;
    logic [1:0]        e_be;
    logic [15:0]       e_wdata;
    logic              e_dir;
    logic [15:0]       e_dout;
  } vec_t;

  task automatic chk(input string name, input int cyc, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", name, cyc, got, exp);
    end
  endtask

  function automatic vec_t mkv(logic rd, logic [1:0] be, logic [ADDR_W-1:0] addr, logic [15:0] wdata,
                               logic [15:0] rdata, int dly, logic tied, logic abort, int hold,
                               logic [ADDR_W-1:0] e_addr, logic e_we, logic [1:0] e_be,
                               logic [15:0] e_wdata, logic e_dir, logic [15:0] e_dout);
    vec_t v;
    v.rd = rd; v.be = be; v.addr = addr; v.wdata = wdata; v.rdata = rdata;
    v.dly = dly; v.tied = tied; v.abort = abort; v.hold = hold;
    v.e_addr = e_addr; v.e_we = e_we; v.e_be = e_be; v.e_wdata = e_wdata;
    v.e_dir = e_dir; v.e_dout = e_dout;
    return v;
  endfunction

  // Reference model: a cycle forwards the CPU's address, direction, strobes and data untouched,
  // the buffer turns around only for reads, and the slave's word is returned whole.
  function automatic vec_t mk_rand();
    vec_t v;
    logic [1:0] be_opts [3];
    be_opts[0] = 2'b01; be_opts[1] = 2'b10; be_opts[2] = 2'b11;
    v.rd    = 1'($urandom_range(0, 1));
    v.be    = be_opts[$urandom_range(0, 2)];
    v.addr  = ADDR_W'($urandom);
    v.wdata = 16'($urandom);
    v.rdata = 16'($urandom);
    v.dly   = $urandom_range(0, 4);
    v.tied  = 1'b0;
    v.abort = ($urandom_range(0, 4) == 0);
    v.hold  = $urandom_range(1, 3);
    v.e_addr  = v.addr;
    v.e_we    = !v.rd;
    v.e_be    = v.be;
    v.e_wdata = v.wdata;
    v.e_dir   = v.rd;
    v.e_dout  = v.rdata;
    return v;
  endfunction

  task automatic pins_idle();
    bus.as_n = 1'b1; bus.uds_n = 1'b1; bus.lds_n = 1'b1;
  endtask

  // Edge n is the n-th rising edge after the pins fall. Sync'd strobes appear after edge S,
  // req after S+2, DTACK on the ack edge, and release S edges after the AS pin rises.
  task automatic run_txn(input vec_t v);
    int  ackn, m, last;
    logic exp_req, in_dt;
    ackn = S + 3 + v.dly;
    m    = v.abort ? ackn : ackn + v.hold;
    last = m + S + 1;
    @(negedge clk12);
    bus.as_n = 1'b0; bus.uds_n = ~v.be[1]; bus.lds_n = ~v.be[0]; bus.r_w_n = v.rd;
    bus.addr_in = v.addr; bus.data_in = v.wdata; bus.rdata = v.rdata;
    bus.ack = v.tied;
    for (int n = 1; n <= last; n++) begin
      @(posedge clk12); #1;
      exp_req = (n >= S + 2) && (v.abort ? (n <= m + S - 1) : (n <= ackn - 1));
      in_dt   = !v.abort && (n >= ackn) && (n <= m + S - 1);
      chk("req", n, 32'(bus.req), 32'(exp_req));
      chk("dtack_n", n, 32'(bus.dtack_n), 32'(!in_dt));
      chk("dir", n, 32'(bus.dir), 32'(in_dt && v.e_dir));
      chk("berr_n", n, 32'(bus.berr_n), 32'd1);
      if (n == S + 2) begin
        chk("req_addr", n, 32'(bus.req_addr), 32'(v.e_addr));
        chk("req_we", n, 32'(bus.req_we), 32'(v.e_we));
        chk("req_be", n, 32'(bus.req_be), 32'(v.e_be));
        chk("req_wdata", n, 32'(bus.req_wdata), 32'(v.e_wdata));
      end
      if (in_dt) chk("data_out", n, 32'(bus.data_out), 32'(v.e_dout));
      @(negedge clk12);
      if (n + 1 >= m) pins_idle();
      bus.ack = v.tied || (!v.abort && (n + 1 == ackn));
    end
    bus.ack = 1'b0;
    repeat (2) @(posedge clk12);
  endtask

  vec_t vecs [8];

  initial begin
    vec_t v;
    int   cnt;
    bit   seen;

    vecs[0] = mkv(1, 2'b11, 23'h000010, 16'h0000, 16'hBEEF, 1, 0, 0, 2, 23'h000010, 0, 2'b11, 16'h0000, 1, 16'hBEEF);
    vecs[1] = mkv(0, 2'b01, 23'h000400, 16'h00A5, 16'h0000, 0, 0, 0, 1, 23'h000400, 1, 2'b01, 16'h00A5, 0, 16'h0000);
    vecs[2] = mkv(0, 2'b10, 23'h7FFFFF, 16'hA500, 16'h1234, 2, 0, 0, 3, 23'h7FFFFF, 1, 2'b10, 16'hA500, 0, 16'h1234);
    vecs[3] = mkv(1, 2'b01, 23'h2AAAAA, 16'h0F0F, 16'h00C3, 3, 0, 0, 1, 23'h2AAAAA, 0, 2'b01, 16'h0F0F, 1, 16'h00C3);
    vecs[4] = mkv(1, 2'b11, 23'h000123, 16'h0000, 16'h5A5A, 0, 1, 0, 2, 23'h000123, 0, 2'b11, 16'h0000, 1, 16'h5A5A);
    vecs[5] = mkv(1, 2'b11, 23'h000040, 16'h1111, 16'h2222, 2, 0, 1, 1, 23'h000040, 0, 2'b11, 16'h1111, 1, 16'h2222);
    vecs[6] = mkv(0, 2'b11, 23'h000041, 16'hFFFF, 16'h0000, 0, 0, 0, 3, 23'h000041, 1, 2'b11, 16'hFFFF, 0, 16'h0000);
    vecs[7] = mkv(0, 2'b11, 23'h055555, 16'hC0DE, 16'h8001, 0, 1, 0, 1, 23'h055555, 1, 2'b11, 16'hC0DE, 0, 16'h8001);

    pins_idle();
    bus.r_w_n = 1'b1; bus.addr_in = '0; bus.data_in = '0; bus.ack = 1'b0; bus.rdata = '0;
    repeat (3) @(posedge clk12);
    #1;
    chk("rst_dtack_n", 0, 32'(bus.dtack_n), 32'd1);
    chk("rst_berr_n", 0, 32'(bus.berr_n), 32'd1);
    chk("rst_dir", 0, 32'(bus.dir), 32'd0);
    chk("rst_req", 0, 32'(bus.req), 32'd0);
    chk("rst_data_out", 0, 32'(bus.data_out), 32'd0);
    chk("rst_req_addr", 0, 32'(bus.req_addr), 32'd0);
    chk("rst_req_we", 0, 32'(bus.req_we), 32'd0);
    chk("rst_req_be", 0, 32'(bus.req_be), 32'd0);
    chk("rst_req_wdata", 0, 32'(bus.req_wdata), 32'd0);
    @(negedge clk12);
    rst = 1'b0;
    repeat (S + 3) @(posedge clk12);

    for (int i = 0; i < 8; i++) run_txn(vecs[i]);
    for (int i = 0; i < 40; i++) begin
      v = mk_rand();
      run_txn(v);
    end

    // Reset while DTACK is asserted and AS stays low: no new cycle until AS is seen high.
    @(negedge clk12);
    bus.as_n = 1'b0; bus.uds_n = 1'b0; bus.lds_n = 1'b0; bus.r_w_n = 1'b1;
    bus.addr_in = 23'h000777; bus.rdata = 16'h4321; bus.ack = 1'b1;
    seen = 1'b0;
    for (int n = 0; n < 20 && !seen; n++) begin
      @(posedge clk12); #1;
      seen = (bus.dtack_n == 1'b0);
    end
    chk("rst_seq_dtack_seen", 0, 32'(seen), 32'd1);
    @(negedge clk12);
    rst = 1'b1; bus.ack = 1'b0;
    @(posedge clk12); #1;
    chk("midrst_dtack_n", 1, 32'(bus.dtack_n), 32'd1);
    chk("midrst_dir", 1, 32'(bus.dir), 32'd0);
    chk("midrst_data_out", 1, 32'(bus.data_out), 32'd0);
    chk("midrst_req_addr", 1, 32'(bus.req_addr), 32'd0);
    @(negedge clk12);
    rst = 1'b0;
    for (int n = 1; n <= 10; n++) begin
      @(posedge clk12); #1;
      chk("midrst_no_req", n, 32'(bus.req), 32'd0);
      chk("midrst_no_dtack", n, 32'(bus.dtack_n), 32'd1);
    end
    @(negedge clk12);
    pins_idle();
    repeat (S + 2) @(posedge clk12);
    run_txn(vecs[0]);

`ifdef M68K_BUS_TIMEOUT_EN
    // Slave never answers: req lasts exactly TO cycles, then BERR until AS is seen high.
    @(negedge clk12);
    bus.as_n = 1'b0; bus.uds_n = 1'b0; bus.lds_n = 1'b0; bus.r_w_n = 1'b1; bus.ack = 1'b0;
    cnt = 0;
    for (int n = 1; n <= S + 2 + TO + 3; n++) begin
      @(posedge clk12); #1;
      if (bus.req) cnt++;
      chk("tmo_dtack_n", n, 32'(bus.dtack_n), 32'd1);
      chk("tmo_berr_n", n, 32'(bus.berr_n), 32'(n < S + 2 + TO));
    end
    chk("tmo_req_cycles", 0, 32'(cnt), 32'(TO));
    @(negedge clk12);
    pins_idle();
    for (int k = 1; k <= S + 1; k++) begin
      @(posedge clk12); #1;
      chk("tmo_berr_release", k, 32'(bus.berr_n), 32'(k > S));
    end
    repeat (2) @(posedge clk12);
    run_txn(vecs[1]);
`else
    cnt = 0;
    chk("no_tmo_berr_n", 0, 32'(bus.berr_n), 32'd1);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog cyc=0 got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end
endmodule
